// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: sequencing states and
// the default width, step and reset-vector constants.
package pc_gen_pkg;

  localparam int PC_XLEN_DEFAULT = 32;
  localparam int PC_STEP_DEFAULT = 4;
  localparam logic [PC_XLEN_DEFAULT-1:0] PC_RESET_VEC_DEFAULT = '0;

  // BOOT: one idle cycle after reset release, no PC offered.
  // RUN: PC offered to fetch every cycle.
  // HALTED: PC frozen and not offered until resume or trap.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// Program-counter generator. Issues a registered fetch PC with a valid/ready
// handshake, steps by STEP on each accepted PC, and services trap, redirect,
// halt and resume requests with fixed priority trap > redirect > halt > fire.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                XLEN        = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0]   RESET_VEC   = XLEN'(PC_RESET_VEC_DEFAULT),
  parameter int                STEP        = PC_STEP_DEFAULT,
  parameter bit                CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            misalign,
  output logic            halted
);

  // STEP is a power of two, so the low bits below it must be zero for an
  // aligned target.
  localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = STEP_W - 1'b1;

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_misalign;
  logic            r_halted;

  logic            w_fire;
  logic            w_target_bad;
  logic            w_redir_ok;
  logic            w_redir_bad;
  logic [XLEN-1:0] w_pc_inc;

  // Decode this cycle's events; BOOT is excluded in the FSM itself.
  always_comb begin
    w_fire       = r_pc_valid & pc_ready;
    w_target_bad = CHECK_ALIGN && ((redirect_target & ALIGN_MASK) != '0);
    w_redir_ok   = redirect_valid & ~w_target_bad;
    w_redir_bad  = redirect_valid &  w_target_bad;
    // Natural XLEN-bit addition gives the required modulo-2^XLEN wrap.
    w_pc_inc     = r_pc + STEP_W;
  end

  // Sequencing FSM with all outputs registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      // Misalign is a single-cycle pulse unless re-armed below.
      r_misalign <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          // All requests are ignored while booting.
          r_state    <= ST_RUN;
          r_pc_valid <= 1'b1;
        end

        ST_RUN: begin
          if (trap_valid) begin
            r_pc <= trap_vec;
          end else if (w_redir_ok) begin
            r_pc <= redirect_target;
          end else if (w_redir_bad) begin
            // Rejected redirect consumes the cycle: pc and state hold.
            r_misalign <= 1'b1;
          end else if (halt_req) begin
            // Halt wins over a same-cycle fire: the PC is reissued on resume.
            r_state    <= ST_HALTED;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b1;
          end else if (w_fire) begin
            r_pc <= w_pc_inc;
          end
        end

        ST_HALTED: begin
          if (trap_valid) begin
            r_pc       <= trap_vec;
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end else if (w_redir_ok) begin
            r_pc <= redirect_target;
          end else if (w_redir_bad) begin
            r_misalign <= 1'b1;
          end else if (resume) begin
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean boot.
          r_state    <= ST_BOOT;
          r_pc       <= RESET_VEC;
          r_pc_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign misalign     = r_misalign;
  assign halted       = r_halted;
  assign pc_plus_step = w_pc_inc;

endmodule : pc_gen

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-003 SHALL have parameter STEP, default 4, sequential increment in bytes; power of two, 2 or greater.
REQ-004 SHALL have parameter CHECK_ALIGN, default 1, enabling misaligned-redirect detection.
REQ-005 SHALL have port clk  input  1  sole clock; rising edge active.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target  input  XLEN  branch/jump destination.
REQ-009 SHALL have port trap_valid  input  1  trap/exception redirect request.
REQ-010 SHALL have port trap_vec  input  XLEN  trap handler address.
REQ-011 SHALL have port halt_req  input  1  request to stop issuing PCs.
REQ-012 SHALL have port resume  input  1  leave halted state.
REQ-013 SHALL have port pc_valid  output  1  pc is valid for fetch.
REQ-014 SHALL have port pc_ready  input  1  fetch unit accepts pc.
REQ-015 SHALL have port pc  output  XLEN  current fetch PC (registered).
REQ-016 SHALL have port pc_plus_step  output  XLEN  pc + STEP (combinational, link value).
REQ-017 SHALL have port misalign  output  1  one-cycle pulse: misaligned redirect rejected.
REQ-018 SHALL have port halted  output  1  high while in HALTED.

Function
REQ-019 SHALL implement states BOOT, RUN, HALTED; BOOT -> RUN unconditionally one cycle after reset release.
REQ-020 SHALL drive pc_valid = 1 only in RUN; fire = pc_valid & pc_ready.
REQ-021 SHALL apply per-cycle priority trap > redirect > halt_req > fire > hold.
REQ-022 SHALL, on trap_valid in RUN or HALTED, load pc <= trap_vec next cycle and enter RUN, regardless of pc_ready.
REQ-023 SHALL, on redirect_valid in RUN or HALTED with aligned target, load pc <= redirect_target next cycle without changing state, regardless of pc_ready (flush).
REQ-024 SHALL, when CHECK_ALIGN=1 and redirect_target mod STEP != 0, keep pc unchanged, ignore the redirect, and pulse misalign for exactly one cycle.
REQ-025 SHALL, on fire with no higher-priority event, load pc <= pc + STEP, wrapping modulo 2^XLEN.
REQ-026 SHALL hold pc stable while pc_valid & !pc_ready and no trap/redirect occurs.
REQ-027 SHALL, on halt_req in RUN, enter HALTED next cycle, holding pc, even if fire occurs the same cycle.
REQ-028 SHALL, on resume in HALTED, enter RUN next cycle with pc unchanged; resume in RUN and halt_req in HALTED are ignored.
REQ-029 SHALL ignore redirect_valid, trap_valid, halt_req and resume in BOOT.
REQ-030 SHALL compute pc_plus_step = pc + STEP truncated to XLEN bits.

Reset
REQ-031 SHALL, while rst_n = 0, force state = BOOT, pc = RESET_VEC, pc_valid = 0, misalign = 0, halted = 0, asynchronously.
REQ-032 SHALL abandon any pending or in-flight handshake on mid-operation reset; no state survives reset.

Structure
REQ-033 SHALL define the state enum and default XLEN/STEP/RESET_VEC constants in shared package pc_gen_pkg.
REQ-034 SHALL be a single module with no sub-modules; alignment check is inline logic.

Verification (XLEN=32, RESET_VEC=0x8000_0000, STEP=4)
REQ-035 SHALL cover reset then pc_ready=1 held -> pc_valid low 1 cycle, then pc = 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
REQ-036 SHALL cover pc_ready=0 for 3 cycles at pc=0x8000_0008 -> pc held; redirect to 0x8000_0100 during the stall -> pc=0x8000_0100 next cycle.
REQ-037 SHALL cover redirect_target=0x8000_0102 -> pc unchanged, misalign high exactly 1 cycle.
REQ-038 SHALL cover trap_valid and redirect_valid together (trap_vec=0x8000_0200) -> pc=0x8000_0200; trap during HALTED -> RUN with pc=trap_vec.
REQ-039 SHALL cover halt_req with fire -> HALTED, pc_valid=0, pc held; resume -> RUN, same pc reissued.
REQ-040 SHALL cover pc=0xFFFF_FFFC with fire -> pc=0x0000_0000; rst_n low mid-stall -> pc=0x8000_0000 immediately.
